// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data memory.
package dmem_pkg;

  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned DATA_W     = 8 * BYTE_LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [31:0]            addr;
    logic                   write;
    logic [BYTE_LANES-1:0]  size;
    logic [DATA_W-1:0]      wdata;
  } dmem_req_t;

  function automatic int unsigned bank_bits(input int unsigned n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One word-wide bank: active-high en/we/be mapped onto the active-low SRAM pins.
module dmem_bank #(
  parameter  int unsigned WORDS = 256,
  localparam int unsigned ROW_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [ROW_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic        cen;
  logic        gwen;
  logic [31:0] wen;

  assign cen  = ~en;
  assign gwen = ~we;

  always_comb begin
    wen = '1;
    for (int i = 0; i < 4; i++) wen[8*i +: 8] = {8{~be[i]}};
  end

  generate
    if (WORDS == 1024) begin : g_macro
      sram_4k u_sram (
        .CLK  (clk),
        .CEN  (cen),
        .GWEN (gwen),
        .WEN  (wen),
        .A    (10'(addr)),
        .D    (wdata),
        .EMA  (3'b000),
        .RETN (1'b1),
        .Q    (rdata)
      );
    end else begin : g_array
      logic [31:0] mem [WORDS];

      always_ff @(posedge clk) begin
        if (!cen) begin
          if (!gwen) mem[addr] <= (mem[addr] & wen) | (wdata & ~wen);
          else       rdata     <= mem[addr];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sram_4k.sv
// Behavioural stand-in for the 1024x32 SRAM macro: active-low CEN/GWEN and per-bit WEN.
module sram_4k (
  input  logic        CLK,
  input  logic        CEN,
  input  logic        GWEN,
  input  logic [31:0] WEN,
  input  logic [9:0]  A,
  input  logic [31:0] D,
  input  logic [2:0]  EMA,
  input  logic        RETN,
  output logic [31:0] Q
);

  logic [31:0] mem [1024];
  logic        unused_pins;

  // Margin and retention pins have no behavioural effect.
  assign unused_pins = ^{EMA, RETN};

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       Q      <= mem[A];
    end
  end

endmodule

// File: rtl/dmem_banked.sv
// Word-interleaved banked data memory with a valid/ready request/response port and response skid.
// Optional out-of-range error reporting is enabled by defining DMEM_ERR_EN.
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = 4096,
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [3:0]  i_req_size,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned BB         = bank_bits(NUM_BANKS);
  localparam int unsigned BANK_IW    = (BB > 0) ? BB : 1;
  localparam int unsigned WORD_W     = MEM_ADDR_WIDTH - 2;
  localparam int unsigned ROW_W      = WORD_W - BB;
  localparam int unsigned BANK_WORDS = MEM_DEPTH / (BYTE_LANES * NUM_BANKS);

  dmem_req_t           req;
  dmem_state_e         state;
  logic [WORD_W-1:0]   word;
  logic [BANK_IW-1:0]  bank_c;
  logic [ROW_W-1:0]    row_c;
  logic                oor_c;
  logic                accept_c;
  logic                unused_addr;
  logic [NUM_BANKS-1:0] bank_en;
  logic [31:0]         bank_q [NUM_BANKS];

  logic [BANK_IW-1:0]  bank_sel_q;
  logic                err_q;
  logic                load_q;
  logic [31:0]         skid_data;
  logic                skid_err;
  logic [31:0]         live_data_c;

  assign req = '{addr: i_req_addr, write: i_req_write, size: i_req_size, wdata: i_req_wdata};

  // Byte offset is ignored; upper bits only matter for range checking.
  assign unused_addr = ^{req.addr[1:0], req.addr[31:MEM_ADDR_WIDTH]};

  assign word   = req.addr[MEM_ADDR_WIDTH-1:2];
  assign bank_c = BANK_IW'(word & WORD_W'(NUM_BANKS - 1));
  assign row_c  = ROW_W'(word >> BB);

`ifdef DMEM_ERR_EN
  assign oor_c = |req.addr[31:MEM_ADDR_WIDTH];
`else
  assign oor_c = 1'b0;
`endif

  // A response slot frees up in the same cycle it is consumed.
  assign o_req_ready = ~i_rst & ((state == IDLE) | i_rsp_ready);
  assign accept_c    = i_req_valid & o_req_ready;

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign bank_en[b] = accept_c & ~oor_c & (bank_c == BANK_IW'(b));

      dmem_bank #(.WORDS(BANK_WORDS)) u_bank (
        .clk   (i_clk),
        .en    (bank_en[b]),
        .we    (req.write),
        .be    (req.size),
        .addr  (row_c),
        .wdata (req.wdata),
        .rdata (bank_q[b])
      );
    end
  endgenerate

  always_comb begin
    live_data_c = '0;
    if (load_q && !err_q) live_data_c = bank_q[bank_sel_q];
  end

  assign o_rsp_valid = (state != IDLE);
  assign o_rsp_rdata = (state == RESP) ? live_data_c :
                       (state == HOLD) ? skid_data   : '0;
  assign o_rsp_err   = (state == RESP) ? err_q :
                       (state == HOLD) ? skid_err : 1'b0;

  // Response FSM; bank Q is only valid for one cycle, so a stalled response moves to the skid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      bank_sel_q <= '0;
      err_q      <= 1'b0;
      load_q     <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else begin
      if (accept_c) begin
        bank_sel_q <= bank_c;
        err_q      <= oor_c;
        load_q     <= ~req.write;
      end
      unique case (state)
        IDLE: if (accept_c) state <= RESP;
        RESP: begin
          if (i_rsp_ready) begin
            state <= accept_c ? RESP : IDLE;
          end else begin
            skid_data <= live_data_c;
            skid_err  <= err_q;
            state     <= HOLD;
          end
        end
        HOLD: if (i_rsp_ready) state <= accept_c ? RESP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_banked.sv
// Directed plus randomized bench for dmem_banked against a byte-array reference model.
`timescale 1ns/1ps
module tb_dmem_banked;

  localparam int unsigned MEM_DEPTH = 4096;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [3:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  logic [7:0] ref_mem [MEM_DEPTH];

  always #5 clk = ~clk;

  dmem_banked #(.MEM_DEPTH(4096), .NUM_BANKS(4), .MEM_ADDR_WIDTH(12)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_write (req_write),
    .i_req_size  (req_size),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  function automatic bit ref_err(input logic [31:0] a);
    return ERR_EN && (a >= 32'(MEM_DEPTH));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a);
    int unsigned base;
    base = (a % MEM_DEPTH) & ~32'd3;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    int unsigned base;
    base = (a % MEM_DEPTH) & ~32'd3;
    for (int i = 0; i < 4; i++) if (m[i]) ref_mem[base+i] = d[8*i +: 8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; response checked the cycle after accept, then optionally stalled.
  task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                      input logic [3:0] m, input logic [31:0] d, input int stall);
    logic [31:0] exp_d;
    logic        exp_e;
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_size  = m;
    req_wdata = d;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    exp_e = ref_err(a);
    exp_d = (w || exp_e) ? 32'd0 : ref_load(a);
    if (w && !exp_e) ref_store(a, m, d);
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rdata"}, rsp_rdata, exp_d);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    if (stall > 0) begin
      // A pending store while stalled must not be accepted.
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = $urandom;
      req_size  = 4'hF;
      req_wdata = $urandom;
      for (int i = 0; i < stall; i++) begin
        #1;
        check({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_stall_rdata"}, rsp_rdata, exp_d);
        check({tag, "_stall_err"}, 32'(rsp_err), 32'(exp_e));
      end
      req_valid = 1'b0;
    end
  endtask

  task automatic idle(input string tag);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle_rdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          st;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_size = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Reset then idle
    tick(); tick();
    check("rst_ready_low", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_rdata", rsp_rdata, 32'd0);
    check("post_rst_err", 32'(rsp_err), 32'd0);

    // Give every word a known value so the model matches the SRAM.
    for (int w = 0; w < int'(MEM_DEPTH / 4); w++) xfer("fill", 32'(w * 4), 1'b1, 4'hF, $urandom, 0);
    idle("fill");

    // Byte-masked stores and load-after-store
    xfer("t2_st_full", 32'h010, 1'b1, 4'hF, 32'hDEADBEEF, 0);
    xfer("t2_st_byte", 32'h010, 1'b1, 4'h1, 32'h000000AA, 0);
    xfer("t2_ld", 32'h010, 1'b0, 4'h0, 32'h0, 0);
    check("t2_exact", rsp_rdata, 32'hDEADBEAA);
    xfer("t2_nop_st", 32'h010, 1'b1, 4'h0, 32'hFFFFFFFF, 0);
    xfer("t2_ld2", 32'h013, 1'b0, 4'hF, 32'h0, 0);
    check("t2_nop_exact", rsp_rdata, 32'hDEADBEAA);
    idle("t2");

    // Streaming across all four banks
    for (int i = 0; i < 4; i++) xfer("t3_st", 32'(i * 4), 1'b1, 4'hF, 32'(i + 1), 0);
    for (int i = 0; i < 4; i++) begin
      xfer("t3_ld", 32'(i * 4), 1'b0, 4'h0, 32'h0, 0);
      check("t3_exact", rsp_rdata, 32'(i + 1));
    end
    idle("t3");

    // Backpressure; next request accepted on release
    xfer("t4_ld", 32'h004, 1'b0, 4'h0, 32'h0, 3);
    xfer("t4_next", 32'h008, 1'b0, 4'h0, 32'h0, 0);
    check("t4_next_exact", rsp_rdata, 32'd3);
    idle("t4");

    // Out-of-range access
    xfer("t5_ld_oor", 32'h1000, 1'b0, 4'h0, 32'h0, 0);
    xfer("t5_st_oor", 32'h1000, 1'b1, 4'hF, 32'h55667788, 0);
    xfer("t5_ld0", 32'h000, 1'b0, 4'h0, 32'h0, 0);
    check("t5_alias", rsp_rdata, ERR_EN ? 32'd1 : 32'h55667788);
    idle("t5");

    // Reset while holding a stalled response
    xfer("t6_ld", 32'h00C, 1'b0, 4'h0, 32'h0, 2);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    xfer("t6_reload", 32'h00C, 1'b0, 4'h0, 32'h0, 0);
    check("t6_exact", rsp_rdata, 32'd4);
    idle("t6");

    // Randomized mix of loads/stores, stalls and gaps
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 2 * MEM_DEPTH - 1);
        1:       a = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
        default: a = 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      endcase
      st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      xfer("rnd", a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, st);
      if ($urandom_range(0, 7) == 0) idle("rnd");
    end
    idle("end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
